// File: rtl/msg_pkg.sv
// Shared types, widths and beat-shaping helpers for the message serializer.
package msg_pkg;

  localparam int unsigned MAX_MSG_BYTES = 32;
  localparam int unsigned DATA_BYTES    = 8;
  localparam int unsigned TKEEP_WIDTH   = DATA_BYTES;
  localparam int unsigned FIFO_DEPTH    = 4;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned MSG_W      = 8 * MAX_MSG_BYTES;
  localparam int unsigned BEAT_W     = 8 * DATA_BYTES;
  localparam int unsigned MAX_BEATS  = MAX_MSG_BYTES / DATA_BYTES;
  localparam int unsigned BIDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned BCNT_W     = BIDX_W + 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned KEEP_EXT_W = TKEEP_WIDTH + 1;
  localparam int unsigned ENTRY_W    = LEN_W + MSG_W + 1;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [MSG_W-1:0] data;
    logic             err;
  } msg_entry_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_t;

  // A stored len of 0 marks an error-only entry, which goes out as a single beat.
  function automatic logic [BCNT_W-1:0] beats_f(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] n;
    n = (len + LEN_W'(DATA_BYTES - 1)) / LEN_W'(DATA_BYTES);
    if (len == '0) return BCNT_W'(1);
    return BCNT_W'(n);
  endfunction

  function automatic logic [TKEEP_WIDTH-1:0] last_keep_f(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0]      rem;
    logic [KEEP_EXT_W-1:0] mask;
    rem  = len % LEN_W'(DATA_BYTES);
    mask = (KEEP_EXT_W'(1) << rem) - KEEP_EXT_W'(1);
    if (len == '0) return TKEEP_WIDTH'(1);
    if (rem == '0) return '1;
    return TKEEP_WIDTH'(mask);
  endfunction

  function automatic logic [BEAT_W-1:0] beat_data_f(input msg_entry_t e,
                                                    input logic [BIDX_W-1:0] idx);
    return BEAT_W'(e.data >> (32'(idx) * BEAT_W));
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Message-entry FIFO; exposes the head and the entry behind it for bubble-free reload.
module msg_fifo
  import msg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [ENTRY_W-1:0] next_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o
);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PTR_W'(1)];
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/msg_serializer.sv
// Buffers parser messages and replays each as an AXI-Stream burst, LSB byte first.
module msg_serializer
  import msg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   msg_valid,
  input  logic [LEN_W-1:0]       msg_length,
  input  logic [MSG_W-1:0]       msg_data,
  input  logic                   msg_error,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [BEAT_W-1:0]      m_tdata,
  output logic [TKEEP_WIDTH-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic                   m_tuser,
  output logic                   fifo_full,
  output logic [15:0]            drop_count
);

  ser_state_t              state_q, state_d;
  logic [BIDX_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                    tvalid_q, tvalid_d;
  logic [BEAT_W-1:0]       tdata_q, tdata_d;
  logic [TKEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d;
  logic                    tuser_q, tuser_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  msg_entry_t              entry_c, head_c, next_c, ld_entry_c;
  logic [BIDX_W-1:0]       ld_idx_c;
  logic                    ld_c, ld_last_c, push_c, pop_c, drop_c, full_c;
  logic [CNT_W-1:0]        count_c;

  msg_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .din_i   (entry_c),
    .pop_i   (pop_c),
    .head_o  (head_c),
    .next_o  (next_c),
    .count_o (count_c),
    .full_o  (full_c)
  );

  // Ingress: normalise length/error, then push or drop.
  always_comb begin
    entry_c.len  = msg_length;
    entry_c.data = msg_data;
    entry_c.err  = msg_error;
    if (msg_error) begin
      entry_c.len  = '0;
      entry_c.data = '0;
    end else if (msg_length > LEN_W'(MAX_MSG_BYTES)) begin
      entry_c.len = LEN_W'(MAX_MSG_BYTES);
      entry_c.err = 1'b1;
    end
    push_c = msg_valid && (msg_error || (msg_length != '0)) &&
             ((count_c < CNT_W'(FIFO_DEPTH)) || pop_c);
    drop_c = msg_valid && !push_c;
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Egress FSM: pick which beat to load, then shape it in one place.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    pop_c      = 1'b0;
    ld_c       = 1'b0;
    ld_entry_c = head_c;
    ld_idx_c   = '0;
    ld_last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_c != '0) begin
          ld_c    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tvalid_q && m_tready) begin
          if (tlast_q) begin
            pop_c = 1'b1;
            if (count_c > CNT_W'(1)) begin
              ld_c       = 1'b1;
              ld_entry_c = next_c;
            end else begin
              tvalid_d = 1'b0;
              tdata_d  = '0;
              tkeep_d  = '0;
              tlast_d  = 1'b0;
              tuser_d  = 1'b0;
              state_d  = IDLE;
            end
          end else begin
            ld_c     = 1'b1;
            ld_idx_c = beat_cnt_q + BIDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld_c) begin
      ld_last_c  = ((BCNT_W'(ld_idx_c) + BCNT_W'(1)) == beats_f(ld_entry_c.len));
      tvalid_d   = 1'b1;
      tdata_d    = beat_data_f(ld_entry_c, ld_idx_c);
      tkeep_d    = ld_last_c ? last_keep_f(ld_entry_c.len) : '1;
      tlast_d    = ld_last_c;
      tuser_d    = ld_last_c && ld_entry_c.err;
      beat_cnt_d = ld_idx_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign m_tvalid   = tvalid_q;
  assign m_tdata    = tdata_q;
  assign m_tkeep    = tkeep_q;
  assign m_tlast    = tlast_q;
  assign m_tuser    = tuser_q;
  assign fifo_full  = full_c;
  assign drop_count = drop_cnt_q;

endmodule
